// File: rtl/frame_buf_wr_ctrl.sv
// Camera frame-buffer write sequencer: skips start-up frames, buffers pixels, issues burst writes.
// Optional FRAME_BUF_PINGPONG_EN: alternate between two banks so display reads the last full frame.
module frame_buf_wr_ctrl #(
    parameter int IMG_W       = 480,
    parameter int IMG_H       = 272,
    parameter int BURST_LEN   = 64,
    parameter int FIFO_DEPTH  = 256,
    parameter int SKIP_FRAMES = 2,
    parameter int ADDR_W      = 21,
    parameter int BANK_STRIDE = 131072
) (
    input  logic              i_sysclk,
    input  logic              i_sysrst,
    input  logic              i_init_done,
    input  logic              i_vsync,
    input  logic              i_pix_valid,
    input  logic [15:0]       i_pix_data,
    output logic              o_wr_req,
    input  logic              i_wr_ack,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [7:0]        o_wr_len,
    output logic              o_wr_en,
    output logic [15:0]       o_wr_data,
    output logic              o_frame_done,
    output logic              o_rd_bank,
    output logic [1:0]        o_err
);

    localparam int FRAME_PIX = IMG_W * IMG_H;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int XW = $clog2(FRAME_PIX + 1);
    localparam int SW = (SKIP_FRAMES < 1) ? 1 : $clog2(SKIP_FRAMES + 1);

    localparam logic [CW-1:0]     C_BURST  = CW'(BURST_LEN);
    localparam logic [CW-1:0]     C_DEPTH  = CW'(FIFO_DEPTH);
    localparam logic [XW-1:0]     C_FRAME  = XW'(FRAME_PIX);
    localparam logic [XW-1:0]     C_LAST   = XW'(FRAME_PIX - 1);
    localparam logic [SW-1:0]     C_SKIP   = SW'(SKIP_FRAMES);
    localparam logic [7:0]        C_LEN    = 8'(BURST_LEN);
    localparam logic [ADDR_W-1:0] C_STRIDE = ADDR_W'(BANK_STRIDE);

    typedef enum logic [2:0] {S_IDLE, S_WAIT_VS, S_SKIP, S_CAPTURE, S_FLUSH, S_DONE} state_t;

    state_t            r_state, w_nextState;
    logic [15:0]       r_mem [FIFO_DEPTH];
    logic [PW-1:0]     r_wrPtr, r_rdPtr;
    logic [CW-1:0]     r_count;
    logic [XW-1:0]     r_pixCount;
    logic [SW-1:0]     r_skipCnt;
    logic [ADDR_W-1:0] r_offset, r_wrAddr;
    logic [7:0]        r_wrLen, r_beatsLeft;
    logic              r_wrReq, r_vsyncPrev, r_wrBank, r_rdBank;
    logic [1:0]        r_err;

    logic              w_vsRise, w_active, w_pop, w_pixIn, w_lastPix, w_abort;
    logic              w_push, w_overflow, w_issue, w_enterCapture;
    logic [7:0]        w_issueLen, w_keep;
    logic [ADDR_W-1:0] w_bankBase;

    assign w_vsRise   = i_vsync & ~r_vsyncPrev;
    assign w_active   = r_wrReq | (r_beatsLeft != 8'd0);
    assign w_pop      = (r_beatsLeft != 8'd0);
    assign w_pixIn    = (r_state == S_CAPTURE) && i_pix_valid && (r_pixCount < C_FRAME);
    assign w_lastPix  = w_pixIn && (r_pixCount == C_LAST);
    // A vsync rise on the final pixel completes the frame rather than aborting it.
    assign w_abort    = w_vsRise && (((r_state == S_CAPTURE) && !w_lastPix) || (r_state == S_FLUSH));
    assign w_push     = w_pixIn && !w_abort && ((r_count < C_DEPTH) || w_pop);
    assign w_overflow = w_pixIn && !w_abort && !w_push;
    assign w_enterCapture = ((w_nextState == S_CAPTURE) && (r_state != S_CAPTURE)) || w_abort;
    assign w_keep     = r_wrReq ? r_wrLen : r_beatsLeft;
    assign w_bankBase = r_wrBank ? C_STRIDE : '0;

    always_comb begin
        w_nextState = r_state;
        w_issue     = 1'b0;
        w_issueLen  = C_LEN;
        case (r_state)
            S_IDLE:    if (i_init_done) w_nextState = S_WAIT_VS;
            S_WAIT_VS: if (w_vsRise) w_nextState = (r_skipCnt == '0) ? S_CAPTURE : S_SKIP;
            S_SKIP:    if (w_vsRise && (r_skipCnt <= SW'(1))) w_nextState = S_CAPTURE;
            S_CAPTURE: begin
                if (!w_abort) begin
                    w_issue = !w_active && (r_count >= C_BURST);
                    if (w_lastPix) w_nextState = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (w_abort) begin
                    w_nextState = S_CAPTURE;
                end else if (!w_active) begin
                    if (r_count != '0) begin
                        w_issue    = 1'b1;
                        w_issueLen = (r_count >= C_BURST) ? C_LEN : 8'(r_count);
                    end else begin
                        w_nextState = S_DONE;
                    end
                end
            end
            S_DONE:    w_nextState = S_WAIT_VS;
            default:   w_nextState = S_IDLE;
        endcase
        if (!i_init_done) begin
            w_nextState = S_IDLE;
            w_issue     = 1'b0;
        end
    end

    always_ff @(posedge i_sysclk) begin
        if (w_push) r_mem[r_wrPtr] <= i_pix_data;
    end

    always_ff @(posedge i_sysclk) begin
        if (i_sysrst) begin
            r_state     <= S_IDLE;
            r_vsyncPrev <= 1'b0;
            r_skipCnt   <= C_SKIP;
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_count     <= '0;
            r_pixCount  <= '0;
            r_offset    <= '0;
            r_wrAddr    <= '0;
            r_wrLen     <= '0;
            r_beatsLeft <= '0;
            r_wrReq     <= 1'b0;
            r_wrBank    <= 1'b0;
            r_rdBank    <= 1'b0;
            r_err       <= '0;
        end else begin
            r_state     <= w_nextState;
            r_vsyncPrev <= i_vsync;
            if (!i_init_done) begin
                r_wrPtr     <= '0;
                r_rdPtr     <= '0;
                r_count     <= '0;
                r_pixCount  <= '0;
                r_offset    <= '0;
                r_wrReq     <= 1'b0;
                r_beatsLeft <= '0;
            end else begin
                if ((r_state == S_SKIP) && w_vsRise) r_skipCnt <= r_skipCnt - SW'(1);
                if (w_overflow) r_err[0] <= 1'b1;
                if (w_abort)    r_err[1] <= 1'b1;

                if (w_enterCapture)  r_pixCount <= '0;
                else if (w_pixIn)    r_pixCount <= r_pixCount + XW'(1);

                if (w_issue) begin
                    r_wrReq  <= 1'b1;
                    r_wrAddr <= w_bankBase + r_offset;
                    r_wrLen  <= w_issueLen;
                end else if (r_wrReq && i_wr_ack) begin
                    r_wrReq     <= 1'b0;
                    r_beatsLeft <= r_wrLen;
                end else if (w_pop) begin
                    r_beatsLeft <= r_beatsLeft - 8'd1;
                end

                if (w_enterCapture) r_offset <= '0;
                else if (w_issue)   r_offset <= r_offset + ADDR_W'(w_issueLen);

                // On abort only the data owed to the in-flight burst survives the FIFO clear.
                if (w_abort)     r_wrPtr <= r_rdPtr + PW'(w_keep);
                else if (w_push) r_wrPtr <= r_wrPtr + PW'(1);
                if (w_pop)       r_rdPtr <= r_rdPtr + PW'(1);

                if (w_abort)                r_count <= CW'(w_keep) - CW'(w_pop);
                else if (w_push && !w_pop)  r_count <= r_count + CW'(1);
                else if (!w_push && w_pop)  r_count <= r_count - CW'(1);

`ifdef FRAME_BUF_PINGPONG_EN
                if (r_state == S_DONE) begin
                    r_rdBank <= r_wrBank;
                    r_wrBank <= ~r_wrBank;
                end
`endif
            end
        end
    end

    assign o_wr_req     = r_wrReq;
    assign o_wr_addr    = r_wrAddr;
    assign o_wr_len     = r_wrLen;
    assign o_wr_en      = w_pop;
    assign o_wr_data    = w_pop ? r_mem[r_rdPtr] : 16'h0000;
    assign o_frame_done = (r_state == S_DONE);
    assign o_rd_bank    = r_rdBank;
    assign o_err        = r_err;

endmodule
